lsu_ctrl: RTL

//   Load/store initiator in the memory stage of the core; requesting end of the dmem port.

---
 rtl/lsu_ctrl_pkg.sv | 39 +++
 rtl/lsu_ctrl_load_ext.sv | 30 +++
 rtl/lsu_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_pkg.sv
// Shared encodings and decode helpers for the load/store unit.
package lsu_ctrl_pkg;

  // RV32 funct3 codes for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // dmem access size codes
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  // Stores only know B/H/W; loads additionally know BU/HU.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return (f3 > F3_W);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // Access size carried by the low two funct3 bits.
  function automatic logic [1:0] f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_load_ext.sv
// Combinational load-data extension: picks the addressed byte/half/word
// (already rotated into the low lanes by dmem) and sign/zero extends it.
module lsu_ctrl_load_ext
  import lsu_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] r_data,
  output logic [31:0] ext_data
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  assign byte_s = r_data[7:0];
  assign half_s = r_data[15:0];

  // Select and extend according to the load type
  always_comb begin
    ext_data = '0;
    case (funct3)
      F3_B:    ext_data = 32'(byte_s);
      F3_H:    ext_data = 32'(half_s);
      F3_W:    ext_data = r_data;
      F3_BU:   ext_data = {24'd0, r_data[7:0]};
      F3_HU:   ext_data = {16'd0, r_data[15:0]};
      default: ext_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator for the memory stage: accepts one request, issues a
// single dmem strobe, waits for read data on loads (with optional timeout)
// and returns a one-cycle response. All dmem-side and response outputs are
// registered together with the state so they line up with it.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic              stall,
  output logic [ADDR_W-1:0] addr,
  output logic              r_enable,
  output logic              w_enable,
  output logic [1:0]        w_size,
  output logic [31:0]       w_data,
  input  logic              ready,
  input  logic [31:0]       r_data
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [2:0]        op_f3, op_f3_n;
  logic [ADDR_W-1:0] addr_n;
  logic [31:0]       w_data_n, resp_data_n, ext_data;
  logic [1:0]        w_size_n;
  logic              r_enable_n, w_enable_n, resp_valid_n, resp_err_n;
  logic              timeout_hit;

  lsu_ctrl_load_ext u_load_ext (
    .funct3   (op_f3),
    .r_data   (r_data),
    .ext_data (ext_data)
  );

  assign req_ready   = (state == ST_IDLE);
  assign stall       = (state != ST_IDLE) || (req_valid && req_ready);
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  // Next state and next values of the registered outputs
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    op_f3_n      = op_f3;
    addr_n       = addr;
    w_data_n     = w_data;
    w_size_n     = w_size;
    r_enable_n   = 1'b0;
    w_enable_n   = 1'b0;
    resp_valid_n = 1'b0;
    resp_data_n  = '0;
    resp_err_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          addr_n   = req_addr;
          op_f3_n  = req_funct3;
          w_size_n = f3_size(req_funct3);
          if (req_we) w_data_n = req_wdata;
          if (f3_illegal(req_we, req_funct3)) begin
            state_n      = ST_RESP;
            resp_valid_n = 1'b1;
            resp_err_n   = 1'b1;
          end else if (req_we) begin
            state_n    = ST_WR;
            w_enable_n = 1'b1;
          end else begin
            state_n    = ST_RD;
            r_enable_n = 1'b1;
          end
        end
      end
      ST_RD: begin
        state_n = ST_WAIT;
        cnt_n   = '0;
      end
      ST_WAIT: begin
        // Data arriving on the last allowed cycle still counts as success
        if (ready) begin
          state_n      = ST_RESP;
          resp_valid_n = 1'b1;
          resp_data_n  = ext_data;
        end else if (timeout_hit) begin
          state_n      = ST_RESP;
          resp_valid_n = 1'b1;
          resp_err_n   = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_WR: begin
        state_n      = ST_RESP;
        resp_valid_n = 1'b1;
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // State and wait-counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Registered dmem-side and response outputs plus latched request type
  always_ff @(posedge clk) begin
    if (reset) begin
      op_f3      <= '0;
      addr       <= '0;
      w_data     <= '0;
      w_size     <= '0;
      r_enable   <= 1'b0;
      w_enable   <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      op_f3      <= op_f3_n;
      addr       <= addr_n;
      w_data     <= w_data_n;
      w_size     <= w_size_n;
      r_enable   <= r_enable_n;
      w_enable   <= w_enable_n;
      resp_valid <= resp_valid_n;
      resp_data  <= resp_data_n;
      resp_err   <= resp_err_n;
    end
  end

endmodule
